mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Lets the instruction-fetch port (read-only) and the data port (read/write)
// share one mem_system. Each transaction goes through a four-state FSM:
// IDLE arbitrates and latches the winning request, ISSUE drives a one-cycle
// Rd/Wr command, WAIT holds until mem_system raises Done and routes the
// response to the granted port, and FAULT is a dead end entered when the
// watchdog fires. Only rst leaves FAULT.
//
// Data has priority. When both ports are requesting, fetch is guaranteed a
// grant after D_MAX_WINS consecutive contended data grants.
//
// Parameters:
//   D_MAX_WINS  contended data grants allowed before fetch is forced (1..15)
//   TIMEOUT     WAIT cycles without m_done before FAULT; 0 disables (0..255)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_rd, i_addr                  fetch request, held until i_done
//   i_data_out, i_done            fetch response, valid for one cycle
//   i_stall, i_cache_hit          fetch pending flag, forwarded CacheHit
//   d_rd, d_wr, d_addr, d_data_in data request, held until d_done
//   d_data_out, d_done            data response, valid for one cycle
//   d_stall, d_cache_hit          data pending flag, forwarded CacheHit
//   m_addr, m_data_in, m_rd, m_wr command to mem_system (ISSUE only)
//   m_data_out, m_done            response from mem_system
//   m_stall                       mem_system Stall (not used for sequencing)
//   m_cache_hit, m_err            mem_system CacheHit and err
//   err                           watchdog sticky | m_err | illegal-op pulse
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int D_MAX_WINS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    output logic        i_cache_hit,

    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_cache_hit,

    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    input  logic        m_stall,
    input  logic        m_cache_hit,
    input  logic        m_err,

    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [3:0] WIN_LIMIT  = 4'(D_MAX_WINS);
    localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        grant_fetch;
    logic        op_wr;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [3:0]  win_cnt;
    logic [7:0]  timer;
    logic        err_sticky;

    logic        d_req;
    logic        both_req;
    logic        pick_fetch;
    logic        illegal_op;
    logic        done_now;
    logic        issuing;

    // Stall from mem_system is informational only; the FSM sequences
    // purely on Done.
    logic        unused_m_stall;
    assign unused_m_stall = m_stall;

    // Arbitration decision for the current IDLE cycle. Fetch wins when it is
    // alone, or when data has already taken D_MAX_WINS contended grants in a
    // row. Asserting d_rd and d_wr together is served as a write but flagged
    // on err for that cycle.
    always_comb begin
        d_req      = d_rd | d_wr;
        both_req   = i_rd & d_req;
        pick_fetch = i_rd & (~d_req | (win_cnt == WIN_LIMIT));
        illegal_op = (state == IDLE) & d_rd & d_wr;
        done_now   = (state == WAIT) & m_done;
        issuing    = (state == ISSUE);
    end

    // Command to mem_system is driven only during ISSUE so mem_system sees
    // exactly one Rd/Wr per transaction; the latched fields are zeroed in all
    // other states.
    always_comb begin
        m_rd      = issuing & ~op_wr;
        m_wr      = issuing & op_wr;
        m_addr    = issuing ? addr_q  : 16'h0000;
        m_data_in = issuing ? wdata_q : 16'h0000;
    end

    // Response routing. Done, data and CacheHit pass straight through to the
    // granted port in the same cycle m_done arrives; the other port stays 0.
    always_comb begin
        i_done      = done_now & grant_fetch;
        d_done      = done_now & ~grant_fetch;
        i_data_out  = i_done ? m_data_out  : 16'h0000;
        d_data_out  = d_done ? m_data_out  : 16'h0000;
        i_cache_hit = i_done & m_cache_hit;
        d_cache_hit = d_done & m_cache_hit;
        i_stall     = i_rd & ~i_done;
        d_stall     = d_req & ~d_done;
        err         = err_sticky | m_err | illegal_op;
    end

    // Main FSM. The grant, op, address and write data are captured when the
    // request is accepted so the requester's inputs are free to change while
    // the transaction is in flight. win_cnt counts contended data grants only;
    // any fetch grant or uncontended data grant restarts the count. The
    // watchdog timer starts at ISSUE and trips on its TIMEOUT-th WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_fetch <= 1'b0;
            op_wr       <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            win_cnt     <= 4'd0;
            timer       <= 8'd0;
            err_sticky  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rd | d_req) begin
                        state <= ISSUE;
                        if (pick_fetch) begin
                            grant_fetch <= 1'b1;
                            op_wr       <= 1'b0;
                            addr_q      <= i_addr;
                            wdata_q     <= 16'h0000;
                            win_cnt     <= 4'd0;
                        end else begin
                            grant_fetch <= 1'b0;
                            op_wr       <= d_wr;
                            addr_q      <= d_addr;
                            wdata_q     <= d_data_in;
                            if (!both_req) begin
                                win_cnt <= 4'd0;
                            end else if (win_cnt != WIN_LIMIT) begin
                                win_cnt <= win_cnt + 4'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    timer <= 8'd0;
                end
                WAIT: begin
                    if (m_done) begin
                        state <= IDLE;
                    end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
                        err_sticky <= 1'b1;
                        state      <= FAULT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
